// File: rtl/pipe_stage_vr.sv
// One valid/ready register stage. It loads whenever it is empty or its downstream
// neighbour is taking its word this cycle, which lets bubbles collapse.
module pipe_stage_vr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             rdy
);

  logic             vldQ, vldD;
  logic [WIDTH-1:0] datQ, datD;

  assign rdy = !vldQ || dn_ready;
  assign vld = vldQ;
  assign dat = datQ;

  // Bubbles never overwrite the payload, so the last real word stays visible.
  always_comb begin
    vldD = vldQ;
    datD = datQ;
    if (flush) begin
      vldD = 1'b0;
    end else if (rdy) begin
      vldD = up_valid;
      if (up_valid) datD = up_data;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vldQ <= 1'b0;
      datQ <= '0;
    end else begin
      vldQ <= vldD;
      datQ <= datD;
    end
  end

endmodule

// File: rtl/pipe_reg_vr.sv
// Chain of DEPTH valid/ready stages with flush and occupancy count.
// The out_ready -> in_ready path ripples through every stage on purpose.
module pipe_reg_vr #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] vldVec;

  // Each stage keeps its own wires so the ready ripple is not one self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic             stgVld, stgRdy, stgDnRdy, stgUpValid;
    logic [WIDTH-1:0] stgDat, stgUpData;

    if (i == 0) begin : gFirst
      assign stgUpValid = in_valid;
      assign stgUpData  = in_data;
    end else begin : gMid
      assign stgUpValid = gStage[i-1].stgVld;
      assign stgUpData  = gStage[i-1].stgDat;
    end

    if (i == DEPTH - 1) begin : gLast
      assign stgDnRdy = out_ready;
    end else begin : gInner
      assign stgDnRdy = gStage[i+1].stgRdy;
    end

    pipe_stage_vr #(.WIDTH(WIDTH)) uStage (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .flush       (flush),
      .up_valid    (stgUpValid),
      .up_data     (stgUpData),
      .dn_ready    (stgDnRdy),
      .vld         (stgVld),
      .dat         (stgDat),
      .rdy         (stgRdy)
    );

    assign vldVec[i] = stgVld;
  end

  assign in_ready  = gStage[0].stgRdy && !flush;
  assign out_valid = gStage[DEPTH-1].stgVld;
  assign out_data  = gStage[DEPTH-1].stgDat;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(vldVec[i]);
  end

endmodule

// File: tb/tb_pipe_reg_vr.sv
// Bench for pipe_reg_vr (DEPTH=3, WIDTH=8): directed scenarios plus random traffic,
// checked against a queue model that tracks each held word's position in the chain.
module tb_pipe_reg_vr;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             async_rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] qData[$];
  int               qPos[$];
  logic [WIDTH-1:0] lastOut;

  always #5 clk = ~clk;

  pipe_reg_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count)
  );

  function automatic logic expOutValid();
    return (qData.size() > 0) && (qPos[0] == DEPTH - 1);
  endfunction

  function automatic logic expInReady(input logic oR, input logic fl);
    return !fl && ((qData.size() < DEPTH) || oR);
  endfunction

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    doCheck("out_valid", 32'(out_valid), 32'(expOutValid()));
    doCheck("out_data", 32'(out_data), 32'(lastOut));
    doCheck("count", 32'(count), 32'(qData.size()));
    doCheck("in_ready", 32'(in_ready), 32'(expInReady(out_ready, flush)));
  endtask

  task automatic modelClear();
    qData.delete();
    qPos.delete();
  endtask

  // Words move one position per cycle toward the output unless the word ahead blocks them.
  task automatic modelStep(input logic inX, input logic outX, input logic fl,
                           input logic [WIDTH-1:0] d);
    int limit;
    int np;
    if (outX) begin
      void'(qData.pop_front());
      void'(qPos.pop_front());
    end
    if (fl) begin
      modelClear();
      return;
    end
    limit = DEPTH - 1;
    for (int k = 0; k < qData.size(); k++) begin
      np = (qPos[k] + 1 > limit) ? limit : qPos[k] + 1;
      if (np == DEPTH - 1 && qPos[k] != DEPTH - 1) lastOut = qData[k];
      qPos[k] = np;
      limit = np - 1;
    end
    if (inX) begin
      qData.push_back(d);
      qPos.push_back(0);
      if (DEPTH == 1) lastOut = d;
    end
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic oR, input logic fl, output logic accepted);
    logic inX, outX;
    in_valid  = v;
    in_data   = d;
    out_ready = oR;
    flush     = fl;
    #1;
    checkOutput();
    inX  = v && expInReady(oR, fl);
    outX = expOutValid() && oR;
    accepted = inX;
    @(posedge clk);
    modelStep(inX, outX, fl, d);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   guard;

    lastOut     = '0;
    async_rst_n = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'($urandom);
    in_data     = WIDTH'($urandom);
    out_ready   = 1'($urandom);
    #3;
    checkOutput();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = WIDTH'($urandom);
      out_ready = 1'($urandom);
      #1;
      checkOutput();
    end
    @(negedge clk);
    async_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, WIDTH'($urandom), 1'b1, 1'b0, acc);

    $display("[TB] streaming 0x01..0x0A");
    for (int w = 1; w <= 10; w++) applyStimulus(1'b1, WIDTH'(w), 1'b1, 1'b0, acc);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("[TB] back-pressure 0xA1..0xA4");
    for (int w = 0; w < 4; w++) applyStimulus(1'b1, 8'hA1 + 8'(w), 1'b0, 1'b0, acc);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 20) begin
      applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0, acc);
      guard++;
    end
    doCheck("a4_accepted", 32'(acc), 32'(1));
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, acc);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h88, 1'b1, 1'b1, acc);
    doCheck("flush_no_accept", 32'(acc), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++)
      applyStimulus(1'($urandom), WIDTH'($urandom), ($urandom_range(9) < 7),
                    ($urandom_range(19) == 0), acc);

    $display("[TB] async reset mid-stream");
    for (int w = 0; w < 4; w++) applyStimulus(1'b1, 8'hC0 + 8'(w), 1'b1, 1'b0, acc);
    in_valid  = 1'b1;
    in_data   = 8'hCC;
    out_ready = 1'b1;
    flush     = 1'b0;
    #2;
    async_rst_n = 1'b0;
    modelClear();
    lastOut = '0;
    #1;
    checkOutput();
    @(negedge clk);
    async_rst_n = 1'b1;
    for (int w = 0; w < 8; w++) applyStimulus(1'b1, 8'hD0 + 8'(w), 1'b1, 1'b0, acc);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Every word leaving the chain must be the oldest one the model still holds.
  always @(negedge clk) begin
    if (async_rst_n && out_valid && out_ready && qData.size() > 0)
      doCheck("fifo_order", 32'(out_data), 32'(qData[0]));
  end

endmodule
